if_prefetch: RTL
================

# if_prefetch

Parametrised instruction-fetch stage with a prefetch queue. It replaces the single-register fetch stage and decouples instruction SRAM accesses from decode through a DEPTH-entry FIFO, with a valid/ready handshake toward ID. Taken branches redirect the fetch PC, flush every queued entry and squash any in-flight response. It sits between the instruction SRAM port and the ID stage.

## Interface
Parameters:
- RESET_PC, 32'hbfc0_0000: address of the first fetch after reset.
- DEPTH, 4: FIFO entries. Power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- br_e  in  1  taken-branch redirect.
- br_addr  in  32  redirect target, word-aligned.
- id_ready  in  1  ID accepts the head entry this cycle.
- if_valid  out  1  head entry valid.
- if_pc  out  32  PC of the head entry; 0 when if_valid=0.
- if_inst  out  32  instruction of the head entry; 0 when if_valid=0.
- inst_sram_en  out  1  read request this cycle.
- inst_sram_wen  out  4  tied 4'b0.
- inst_sram_addr  out  32  request address, equal to fetch_pc.
- inst_sram_wdata  out  32  tied 32'b0.
- inst_sram_rdata  in  32  read data, valid exactly 1 cycle after a request.

## Operation
- State: fetch_pc (32b); FIFO of {pc, inst}; count (clog2(DEPTH+1) bits); inflight (1b); inflight_pc (32b); squash (1b).
- Issue: inst_sram_en = !rst && !br_e && (count + inflight < DEPTH). The same-cycle dequeue is not credited. On issue: fetch_pc += 4, wrapping mod 2^32; inflight_pc ← fetch_pc; inflight ← 1. With no issue, inflight ← 0.
- Response: in the cycle after an issue, rdata is pushed as {inflight_pc, rdata} unless squash=1, in which case it is discarded.
- Dequeue: a dequeue occurs when if_valid && id_ready && !br_e. The head pointer advances.
- Push and dequeue in the same cycle leave count unchanged. The pointers wrap mod DEPTH.
- Redirect (br_e=1) has highest priority after rst. In that cycle:
  - FIFO flushed (count←0, pointers←0).
  - No issue and no dequeue.
  - fetch_pc ← br_addr.
  - squash ← inflight, so any outstanding response is dropped next cycle.
  - Issue resumes the following cycle at br_addr.
- squash clears in the cycle after it is used.
- The branch delay slot must already have been consumed by ID before br_e is raised. This block does not preserve any entry.
- Full: when count + inflight = DEPTH, no issue. fetch_pc holds.
- Empty: if_valid=0 (except under the bypass in Configuration).

## Timing
- Reset values:
  - fetch_pc=RESET_PC, count=0, inflight=0, squash=0.
  - if_valid=0, if_pc=0, if_inst=0, inst_sram_en=0.
  - inst_sram_addr=RESET_PC.
- rst mid-operation discards the FIFO, the in-flight request and squash in one cycle.
- First request: in the first cycle with rst=0, inst_sram_en=1 and addr=RESET_PC.
- Fetch-to-ID latency is 2 cycles from issue to if_valid (1 cycle with bypass).
- Throughput is one instruction per cycle in steady state for DEPTH ≥ 4, or for DEPTH ≥ 2 with bypass.
- Redirect penalty: first new entry visible 3 cycles after the br_e cycle (2 with bypass).
- Simultaneous br_e and id_ready: the head is not consumed and is flushed.
- Simultaneous br_e and arriving response: the response is dropped.

## Configuration
- IF_BYPASS_EN defined:
  - When count=0, squash=0 and a response arrives, it drives if_valid/if_pc/if_inst combinationally that cycle.
  - If id_ready=1 (and br_e=0), it is consumed and not pushed. Otherwise it is pushed.
- IF_BYPASS_EN undefined:
  - Every response is pushed first.
  - Outputs come only from FIFO registers, so if_inst has no combinational path from inst_sram_rdata.

## Test plan
- Reset release, id_ready=1:
  - addrs bfc00000, bfc00004, … issued on consecutive cycles.
  - if_valid first high 2 cycles after the first issue (1 with bypass), with if_pc=bfc00000.
- id_ready=0 held, DEPTH=4:
  - exactly 4 requests issued, then inst_sram_en=0 and fetch_pc=bfc00010.
  - releasing id_ready drains bfc00000..0c in order, one per cycle.
- br_e pulse with an outstanding request, br_addr=80001000:
  - the stale response is not delivered.
  - next issued addr is 80001000, and the next if_pc seen is 80001000.
- br_e with a full FIFO and id_ready=1 the same cycle:
  - no entry is accepted; count=0 next cycle.
  - issue restarts at br_addr the following cycle.
- fetch_pc=fffffffc, continuous fetch: next addr is 00000000 (wrap), with no stall.
- rst asserted mid-stream with 3 entries queued:
  - next cycle if_valid=0, if_pc=0, if_inst=0.
  - first post-reset request at RESET_PC; no pre-reset instruction is delivered.

Source files
------------

// File: rtl/if_prefetch_if.sv
// Fetch-stage bundle: redirect, ID handshake and instruction SRAM port.
// master = fetch stage, slave = environment (ID stage, branch unit, SRAM).
interface if_prefetch_if;
  logic        br_e;
  logic [31:0] br_addr;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  br_e, br_addr, id_ready, inst_sram_rdata,
    output if_valid, if_pc, if_inst,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output br_e, br_addr, id_ready, inst_sram_rdata,
    input  if_valid, if_pc, if_inst,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_prefetch.sv
// Instruction fetch stage with a DEPTH-entry prefetch FIFO and branch redirect/flush.
// Optional IF_BYPASS_EN: an arriving response is presented to ID directly when the FIFO is empty.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int unsigned DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  if_prefetch_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;
  localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic            squash_q, squash_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic [OccW-1:0] occ;
  logic            issue;
  logic            resp_ok;
  logic            fifo_empty;
  logic            bypass_take;
  logic            push;
  logic            pop;

  // The in-flight request reserves a slot; a same-cycle dequeue is not credited.
  assign occ        = {1'b0, count_q} + OccW'(inflight_q);
  assign fifo_empty = (count_q == '0);
  assign issue      = !rst && !bus.br_e && (occ < DepthOcc);
  assign resp_ok    = inflight_q && !squash_q && !bus.br_e && !rst;

`ifdef IF_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = fifo_empty && !squash_q && inflight_q;
  assign bypass_take = bypass_hit && bus.id_ready && !bus.br_e;
`else
  assign bypass_take = 1'b0;
`endif

  assign push = resp_ok && !bypass_take;
  assign pop  = !fifo_empty && bus.id_ready && !bus.br_e;

  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_inst  = '0;
    if (!fifo_empty) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = pc_mem[rd_ptr_q];
      bus.if_inst  = inst_mem[rd_ptr_q];
    end
`ifdef IF_BYPASS_EN
    else if (bypass_hit) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = inflight_pc_q;
      bus.if_inst  = bus.inst_sram_rdata;
    end
`endif
  end

  assign bus.inst_sram_en    = issue;
  assign bus.inst_sram_wen   = 4'b0;
  assign bus.inst_sram_addr  = fetch_pc_q;
  assign bus.inst_sram_wdata = 32'b0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    squash_d      = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (bus.br_e) begin
      // Flush everything; a request still outstanding gets its response dropped.
      fetch_pc_d = bus.br_addr;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      squash_d   = inflight_q;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_pc_d = fetch_pc_q;
        inflight_d    = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
      inst_mem[wr_ptr_q] <= bus.inst_sram_rdata;
    end
  end

endmodule
